// File: rtl/uart_prog_loader.sv
// UART program loader: 8N1 bytes -> big-endian 32-bit words -> sequential imem writes, CPU held in reset meanwhile.
// Latency: byte ready 2 + DIV/2 + 9*DIV clocks after the start edge; imem_we on the clock after the 4th byte of a word.
// Backpressure: none; rx cannot be stalled, so bytes arriving outside HDR/DATA are simply dropped.
module uart_prog_loader #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              load_en,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              frame_err,
  output logic [ADDR_W:0]   words_written
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV + 1);

  typedef logic [CNT_W-1:0] bcnt_t;
  typedef logic [ADDR_W:0]  wcnt_t;

  // Counters run down to zero, so load one less than the interval length.
  localparam bcnt_t HALF_M1   = bcnt_t'(DIV / 2 - 1);
  localparam bcnt_t FULL_M1   = bcnt_t'(DIV - 1);
  localparam wcnt_t MAX_WORDS = wcnt_t'(2 ** ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERROR} ld_state_t;

  logic      rx_meta, rx_s;
  rx_state_t rx_state;
  bcnt_t     bit_cnt;
  logic [2:0] bit_idx;
  logic [7:0] rx_shift;
  logic      byte_valid, byte_err;

  ld_state_t  ld_state;
  logic       load_en_q;
  wcnt_t      n_words;
  logic [1:0] byte_idx;
  logic [31:0] asm_word;

  logic        load_rise;
  logic        hdr_clamp;
  wcnt_t       hdr_words;
  logic [31:0] next_word;
  wcnt_t       words_inc;

  assign load_rise = load_en & ~load_en_q;
  // Header 0 and anything beyond the memory depth both mean "fill the whole memory".
  assign hdr_clamp = (rx_shift == 8'd0) || (int'(rx_shift) > 2 ** ADDR_W);
  assign hdr_words = hdr_clamp ? MAX_WORDS : wcnt_t'(rx_shift);
  assign next_word = {asm_word[23:0], rx_shift};
  assign words_inc = words_written + 1'b1;

  // Two-flop synchronizer for the asynchronous rx line; idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Byte receiver: mid-bit sampling, LSB first, one-cycle valid/err pulse at the stop-bit midpoint.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            bit_cnt  <= HALF_M1;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (bit_cnt == '0) begin
            if (!rx_s) begin
              bit_cnt  <= FULL_M1;
              bit_idx  <= '0;
              rx_state <= RX_DATA;
            end else begin
              // Line went back high before mid-start: a glitch, not a frame.
              rx_state <= RX_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == '0) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            bit_cnt  <= FULL_M1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 1'b1;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_cnt == '0) begin
            // Leaving at mid-stop leaves half a bit of slack for a back-to-back start edge.
            byte_valid <= rx_s;
            byte_err   <= ~rx_s;
            rx_state   <= RX_IDLE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Loader: header, word assembly, write strobe, hold/done/error status; all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state      <= IDLE;
      // Starts high so a switch left up through reset must be toggled to begin a load.
      load_en_q     <= 1'b1;
      n_words       <= '0;
      byte_idx      <= '0;
      asm_word      <= '0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      frame_err     <= 1'b0;
      words_written <= '0;
    end else begin
      load_en_q <= load_en;
      imem_we   <= 1'b0;
      case (ld_state)
        IDLE: begin
          if (load_rise) begin
            words_written <= '0;
            done          <= 1'b0;
            frame_err     <= 1'b0;
            cpu_hold      <= 1'b1;
            ld_state      <= HDR;
          end
        end
        HDR: begin
          if (!load_en) begin
            cpu_hold <= 1'b0;
            ld_state <= IDLE;
          end else if (byte_err) begin
            frame_err <= 1'b1;
            ld_state  <= ERROR;
          end else if (byte_valid) begin
            n_words  <= hdr_words;
            byte_idx <= '0;
            ld_state <= DATA;
          end
        end
        DATA: begin
          if (!load_en) begin
            cpu_hold <= 1'b0;
            ld_state <= IDLE;
          end else if (byte_err) begin
            frame_err <= 1'b1;
            ld_state  <= ERROR;
          end else if (byte_valid) begin
            asm_word <= next_word;
            if (byte_idx == 2'd3) begin
              // Strobe and data are launched together so they line up with the WRITE cycle.
              imem_we       <= 1'b1;
              imem_addr     <= words_written[ADDR_W-1:0];
              imem_wdata    <= next_word;
              words_written <= words_inc;
              ld_state      <= WRITE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        WRITE: begin
          byte_idx <= '0;
          if (words_written == n_words) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            ld_state <= DONE;
          end else begin
            ld_state <= DATA;
          end
        end
        DONE: ld_state <= IDLE;
        ERROR: begin
          if (!load_en) begin
            cpu_hold <= 1'b0;
            ld_state <= IDLE;
          end
        end
        default: ld_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: serial stimulus at DIV = 16 against a word/address queue model.
// Latency: expected writes are queued per load and consumed whenever imem_we is seen.
// Backpressure: none; the bench paces bytes itself with random idle gaps.
module tb_uart_prog_loader;

  localparam int DIV = 16;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        load_en;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        frame_err;
  logic [6:0]  words_written;

  int          n_checks = 0;
  int          n_pass   = 0;
  wr_t         exp_q[$];
  int          n_we_seen = 0;
  logic [5:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  uart_prog_loader #(.CLK_FREQ(1600), .BAUD(100), .ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .rx(rx), .load_en(load_en),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .frame_err(frame_err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model of header interpretation: 0 or >64 means a full 64-word memory.
  function automatic int model_words(input logic [7:0] hdr);
    if (hdr == 8'd0 || int'(hdr) > 64) return 64;
    return int'(hdr);
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    clks(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      clks(DIV);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    clks(DIV);
    rx = 1'b1;
  endtask

  // Sends header + data and queues the words that must be written, in order.
  task automatic send_load(input logic [7:0] hdr, input logic [7:0] d[$], input int maxgap);
    int words;
    words = d.size() / 4;
    if (words > model_words(hdr)) words = model_words(hdr);
    for (int w = 0; w < words; w++)
      exp_q.push_back(wr_t'{a: 6'(w), d: {d[4*w], d[4*w+1], d[4*w+2], d[4*w+3]}});
    send_byte(hdr, 1'b0);
    clks($urandom_range(0, maxgap));
    foreach (d[i]) begin
      send_byte(d[i], 1'b0);
      clks($urandom_range(0, maxgap));
    end
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic start_load();
    load_en = 1'b0;
    clks(3);
    load_en = 1'b1;
    clks(3);
    check("start_hold", cpu_hold, 1);
    check("start_done_clr", done, 0);
    check("start_ferr_clr", frame_err, 0);
    check("start_words_clr", words_written, 0);
  endtask

  task automatic finish_load(input int n);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("done", done, 1);
    check("words_written", words_written, n);
    check("hold_released", cpu_hold, 0);
    check("frame_err_clear", frame_err, 0);
    check("all_writes_seen", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_hold"}, cpu_hold, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_words"}, words_written, 0);
  endtask

  // Compare process: every write strobe must match the next queued word.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (imem_we === 1'b1) begin
          n_we_seen++;
          last_addr = imem_addr;
          last_data = imem_wdata;
          if (exp_q.size() == 0) begin
            check("unexpected_we", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("we_addr", imem_addr, e.a);
            check("we_data", imem_wdata, e.d);
          end
          check("hold_during_we", cpu_hold, 1);
        end
        if (done === 1'b1) check("done_implies_released", cpu_hold, 0);
      end
    end
  end

  initial begin
    repeat (95000) @(negedge clk);
    $display("FAIL watchdog: cycle budget exhausted, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] h;

    reset = 1'b0; rx = 1'b1; load_en = 1'b0;
    clks(3);
    check_reset_outputs("rst");
    reset = 1'b1;
    clks(5);

    // Fixed two-word load, pinned to literal words.
    start_load();
    n_we_seen = 0;
    send_load(8'h02, '{8'h20, 8'h02, 8'h00, 8'h05, 8'h8C, 8'h03, 8'h00, 8'h04}, 0);
    finish_load(2);
    check("pin_we_count", n_we_seen, 2);
    check("pin_last_addr", last_addr, 6'd1);
    check("pin_last_data", last_data, 32'h8C03_0004);
    clks(50);
    check("done_sticky", done, 1);

    // False start: a 4-clock low glitch must not consume the header slot.
    start_load();
    rx = 1'b0; clks(4); rx = 1'b1;
    clks(3 * DIV);
    check("glitch_no_err", frame_err, 0);
    check("glitch_still_held", cpu_hold, 1);
    rand_bytes(8, q);
    send_load(8'h02, q, 0);
    finish_load(2);

    // A byte in IDLE is dropped, then random loads with random gaps.
    send_byte(8'($urandom_range(1, 255)), 1'b0);
    clks(DIV);
    for (int r = 0; r < 5; r++) begin
      h = 8'($urandom_range(1, 4));
      start_load();
      rand_bytes(4 * int'(h), q);
      send_load(h, q, (r == 0) ? 0 : 24);
      finish_load(int'(h));
    end

    // Bad stop bit on the third data byte.
    start_load();
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    clks(10);
    check("ferr_set", frame_err, 1);
    check("ferr_hold", cpu_hold, 1);
    check("ferr_no_done", done, 0);
    check("ferr_words", words_written, 0);
    load_en = 1'b0;
    clks(3);
    check("ferr_released", cpu_hold, 0);
    check("ferr_sticky", frame_err, 1);
    clks(3 * DIV);

    // Abort after five data bytes: exactly one word reaches memory.
    start_load();
    rand_bytes(5, q);
    send_load(8'h03, q, 0);
    load_en = 1'b0;
    clks(3);
    check("abort_done", done, 0);
    check("abort_hold", cpu_hold, 0);
    check("abort_words", words_written, 1);
    check("abort_ferr", frame_err, 0);
    check("abort_writes", exp_q.size(), 0);

    // Header 0x81 must clamp to 64, not wrap to 1: one word leaves the load open.
    start_load();
    rand_bytes(4, q);
    send_load(8'h81, q, 0);
    clks(20);
    check("clamp_not_done", done, 0);
    check("clamp_hold", cpu_hold, 1);
    check("clamp_words", words_written, 1);
    load_en = 1'b0;
    clks(3);

    // Asynchronous reset during DATA, then a clean reload from address 0.
    start_load();
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h55, 1'b0);
    reset = 1'b0;
    load_en = 1'b0;
    #1;
    check_reset_outputs("midrst");
    clks(3);
    reset = 1'b1;
    clks(5);
    start_load();
    n_we_seen = 0;
    rand_bytes(8, q);
    send_load(8'h02, q, 8);
    finish_load(2);
    check("reload_we_count", n_we_seen, 2);

    // Header 0: full 64-word memory, back-to-back bytes.
    start_load();
    rand_bytes(256, q);
    send_load(8'h00, q, 0);
    finish_load(64);
    check("full_last_addr", last_addr, 6'd63);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial program loader for the single-cycle MIPS board design. Receives an 8N1 UART byte stream from the host, assembles big-endian 32-bit instruction words, and writes them sequentially into instruction memory through a write port. While a load is in progress it holds the CPU in reset, so the processor always starts from address 0 on a freshly written program. It is the input-side counterpart to the display path: the display shows machine state out, and this block puts program state in.

## Interface
Parameters:
- CLK_FREQ, 100_000_000: input clock frequency in Hz.
- BAUD, 115_200: UART bit rate. DIV = CLK_FREQ/BAUD, integer-truncated, clocks per bit.
- ADDR_W, 6: instruction-memory word-address width, giving 64 words and matching the pc[7:2] indexing.

Ports:
- clk, input, 1: system clock (100 MHz board clock, not the 1 Hz CPU clock).
- reset, input, 1: asynchronous, active-low reset.
- rx, input, 1: UART receive line, idles high, asynchronous to clk.
- load_en, input, 1: level from a board switch; its rising edge starts a load.
- imem_we, output, 1: one-cycle write strobe to instruction memory.
- imem_addr, output, ADDR_W: word address for the write.
- imem_wdata, output, 32: word to write.
- cpu_hold, output, 1: ORed into the CPU reset by the top level.
- done, output, 1: the last load completed successfully.
- frame_err, output, 1: sticky; the last load aborted on a bad stop bit.
- words_written, output, ADDR_W+1: count of words written in the current or last load.

## Operation
- rx passes through a 2-flop synchronizer. All rx references below mean the synchronized value.
- Byte receiver FSM, with states RX_IDLE, RX_START, RX_DATA and RX_STOP:
  - RX_IDLE: wait for rx = 0, then load the bit counter with DIV/2 and go to RX_START.
  - RX_START: when the counter expires, sample rx. If 0, go to RX_DATA with the counter set to DIV. If 1, it is a false start: return to RX_IDLE with no byte and no error.
  - RX_DATA: sample 8 bits LSB-first, one every DIV clocks, then go to RX_STOP.
  - RX_STOP: sample after DIV clocks. A 1 produces a one-cycle byte_valid. A 0 produces a one-cycle byte_err. Either way, return to RX_IDLE.
- Loader FSM, with states IDLE, HDR, DATA, WRITE, DONE and ERROR:
  - IDLE: on a rising edge of load_en (registered compare), clear words_written, done and frame_err, then go to HDR. A byte arriving in IDLE is discarded.
  - HDR: the first byte is the word count N. N = 0 means 2^ADDR_W words. N greater than 2^ADDR_W is clamped to 2^ADDR_W. Go to DATA.
  - DATA: shift each received byte into a 32-bit assembly register, first byte in [31:24] and fourth in [7:0]. After the fourth byte, go to WRITE.
  - WRITE: exactly one cycle. imem_we = 1, imem_addr = words_written[ADDR_W-1:0], imem_wdata = the assembled word. words_written increments. If the new count equals N, go to DONE, otherwise return to DATA with the byte index reset to 0.
  - DONE: done = 1. Go to IDLE on the next cycle while keeping done set. done stays set until the next load starts or reset is asserted.
  - ERROR: entered from HDR or DATA on byte_err. Sets frame_err. Exit to IDLE only when load_en = 0.
- cpu_hold = 1 in HDR, DATA, WRITE and ERROR, and 0 in IDLE and DONE.
- load_en falling during HDR or DATA aborts to IDLE. Words already written remain in memory. done stays 0 and frame_err is unchanged.
- imem_addr and imem_wdata are registered and hold their last values outside WRITE.

## Timing
- Reset values: imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_hold = 0, done = 0, frame_err = 0, words_written = 0. Both FSMs reset to their idle state. The synchronizer resets to 1.
- Byte latency: byte_valid fires 2 + DIV/2 + 9·DIV clocks after the rx falling edge (±1).
- imem_we asserts on the clock after the fourth byte's byte_valid.
- cpu_hold rises on the clock after the load_en edge is detected, and falls on the clock after the final WRITE.
- Back-to-back bytes with zero idle between the stop bit and the next start bit must be accepted. The receiver returns to RX_IDLE at the mid-point of the stop bit.
- If reset is asserted mid-load, all outputs return to their reset values immediately (asynchronously). Memory contents are not touched.

## Test plan
All scenarios use CLK_FREQ = 1600 and BAUD = 100, giving DIV = 16.
- Normal 2-word load: load_en 0→1, send 0x02 then 0x20,0x02,0x00,0x05 then 0x8C,0x03,0x00,0x04. Required response: two imem_we pulses, at addr 0 with 0x20020005 and at addr 1 with 0x8C030004. Then done = 1, words_written = 2, and cpu_hold high only during the load.
- Header 0x00: send 256 data bytes. Required response: 64 writes at addrs 0..63, words_written = 64, done = 1.
- Bad stop bit on the third data byte: frame_err = 1, no imem_we pulse, cpu_hold stays 1. Then load_en → 0: cpu_hold drops, frame_err stays 1.
- False start (a low glitch of 4 clocks on rx): no byte is received and no error is flagged. A following 0x02 header is still accepted.
- Abort: load_en falls after 5 data bytes. Required response: one write occurred at addr 0, state returns to IDLE, done = 0, cpu_hold = 0.
- Reset pulse during the DATA state: all outputs are 0 immediately. The next load_en rise loads correctly from addr 0.
